// File: rtl/rl_ram_arb_pkg.sv
// Shared types for the two-requester RAM arbiter: requester index, arbiter state
// record and a one-hot helper.
package rl_ram_arb_pkg;

   localparam int unsigned NREQ = 2;

   typedef logic [$clog2(NREQ)-1:0] req_idx_t;

   typedef struct packed {
      req_idx_t prio;
      logic     lock;
      req_idx_t owner;
      logic     rd_pending;
      req_idx_t rd_owner;
   } arb_state_t;

   function automatic logic [NREQ-1:0] idx_onehot(input req_idx_t idx);
      logic [NREQ-1:0] oh;
      oh      = '0;
      oh[idx] = 1'b1;
      return oh;
   endfunction

endpackage

// File: rtl/rl_ram_1rw.sv
// Single-port RAM with byte enables and a registered read port; the read
// register only loads on reads, so it holds the last value read.
module rl_ram_1rw #(
   parameter int unsigned ABITS = 10,
   parameter int unsigned DBITS = 32,
   localparam int unsigned BW   = (DBITS + 7) / 8
) (
   input  logic             clk_i,
   input  logic             rst_ni,
   input  logic             en_i,
   input  logic             we_i,
   input  logic [ABITS-1:0] addr_i,
   input  logic [BW-1:0]    be_i,
   input  logic [DBITS-1:0] wdata_i,
   output logic [DBITS-1:0] rdata_o
);

   logic [DBITS-1:0] mem [2**ABITS];
   logic [DBITS-1:0] dout_q;

   always_ff @(posedge clk_i) begin
      if (en_i) begin
         if (we_i) begin
            if (rst_ni) begin
               // Per-bit loop so a DBITS that is not a byte multiple still works
               for (int unsigned i = 0; i < DBITS; i++) begin
                  if (be_i[i / 8]) mem[addr_i][i] <= wdata_i[i];
               end
            end
         end else begin
            dout_q <= mem[addr_i];
         end
      end
   end

   assign rdata_o = dout_q;

endmodule

// File: rtl/rl_ram_1rw_arb.sv
// Two-requester round-robin arbiter with lock in front of a single-port RAM;
// grant is combinational and reads return one cycle after acceptance.
module rl_ram_1rw_arb
   import rl_ram_arb_pkg::*;
#(
   parameter int unsigned ABITS = 10,
   parameter int unsigned DBITS = 32,
   localparam int unsigned BW   = (DBITS + 7) / 8
) (
   input  logic                  clk_i,
   input  logic                  rst_i,
   input  logic [NREQ-1:0]       req_i,
   input  logic [NREQ-1:0]       lock_i,
   input  logic [NREQ*ABITS-1:0] addr_i,
   input  logic [NREQ-1:0]       we_i,
   input  logic [NREQ*BW-1:0]    be_i,
   input  logic [NREQ*DBITS-1:0] wdata_i,
   output logic [NREQ-1:0]       gnt_o,
   output logic [NREQ-1:0]       rvalid_o,
   output logic [DBITS-1:0]      rdata_o
);

   arb_state_t       st_q, st_d;
   logic [NREQ-1:0]  gnt;
   logic [NREQ-1:0]  acc;
   req_idx_t         sel;
   logic             ram_en;
   logic             ram_we;
   logic [ABITS-1:0] ram_addr;
   logic [BW-1:0]    ram_be;
   logic [DBITS-1:0] ram_wdata;
   logic [DBITS-1:0] ram_rdata;

   always_comb begin
      gnt = '0;
      if (!rst_i) begin
         if (st_q.lock) begin
            if (req_i[st_q.owner]) gnt = idx_onehot(st_q.owner);
         end else if (&req_i) begin
            gnt = idx_onehot(st_q.prio);
         end else begin
            gnt = req_i;
         end
      end
   end

   assign acc       = req_i & gnt;
   assign sel       = req_idx_t'(acc[1]);
   assign ram_en    = |acc;
   assign ram_we    = ram_en & we_i[sel];
   assign ram_addr  = addr_i[sel*ABITS +: ABITS];
   assign ram_be    = be_i[sel*BW +: BW];
   assign ram_wdata = wdata_i[sel*DBITS +: DBITS];

   always_comb begin
      st_d            = st_q;
      st_d.rd_pending = ram_en & ~we_i[sel];
      st_d.rd_owner   = sel;
      if (st_q.lock) begin
         // Lock drops when the owner stops requesting or is accepted without lock
         if (!req_i[st_q.owner] || (ram_en && !lock_i[st_q.owner])) begin
            st_d.lock = 1'b0;
            st_d.prio = ~st_q.owner;
         end
      end else if (ram_en) begin
         if (lock_i[sel]) begin
            st_d.lock  = 1'b1;
            st_d.owner = sel;
         end else begin
            st_d.prio = ~sel;
         end
      end
   end

   always_ff @(posedge clk_i) begin
      if (rst_i) st_q <= '0;
      else       st_q <= st_d;
   end

   assign gnt_o    = gnt;
   assign rvalid_o = (st_q.rd_pending && !rst_i) ? idx_onehot(st_q.rd_owner) : '0;
   assign rdata_o  = ram_rdata;

   rl_ram_1rw #(
      .ABITS(ABITS),
      .DBITS(DBITS)
   ) u_ram (
      .clk_i  (clk_i),
      .rst_ni (~rst_i),
      .en_i   (ram_en),
      .we_i   (ram_we),
      .addr_i (ram_addr),
      .be_i   (ram_be),
      .wdata_i(ram_wdata),
      .rdata_o(ram_rdata)
   );

endmodule

// File: doc/rl_ram_1rw_arb.md
RL_RAM_1RW_ARB -- requirements
Module: rl_ram_1rw_arb

Interface
REQ-001 Parameter ABITS, default 10, SHALL set the RAM word-address width.
REQ-002 Parameter DBITS, default 32, SHALL set the RAM data width; BW=(DBITS+7)/8.
REQ-003 clk_i  in  1  SHALL be the single clock; all state SHALL update on its rising edge.
REQ-004 rst_i  in  1  SHALL be a synchronous, active-high reset.
REQ-005 req_i  in  2  SHALL be the per-requester access request; bit 0 is requester 0 and bit 1 is requester 1.
REQ-006 lock_i  in  2  SHALL be a per-requester lock; while the grant holder asserts it, the grant is retained.
REQ-007 addr_i  in  2xABITS  SHALL be the per-requester word address.
REQ-008 we_i  in  2  SHALL be the per-requester write enable; 0 means read.
REQ-009 be_i  in  2xBW  SHALL be the per-requester byte enables, valid for writes.
REQ-010 wdata_i  in  2xDBITS  SHALL be the per-requester write data.
REQ-011 gnt_o  out  2  SHALL be a one-hot or zero grant; the request is accepted in any cycle where req_i[n]&gnt_o[n] holds.
REQ-012 rvalid_o  out  2  SHALL pulse for one cycle to mark read data for requester n.
REQ-013 rdata_o  out  DBITS  SHALL be the shared read data, valid only when a rvalid_o bit is set.

Function
REQ-014 gnt_o SHALL be combinational from req_i, lock state and the priority pointer, so a request can be accepted in the cycle it is raised.
REQ-015 Arbitration SHALL be round-robin with a 1-bit pointer prio_q; when both requesters request, grant prio_q.
REQ-016 After any accepted access by requester n without lock, prio_q SHALL become ~n; if no access is accepted, prio_q SHALL hold.
REQ-017 With a single requester, it SHALL be granted regardless of prio_q.
REQ-018 Lock: if requester n is accepted with lock_i[n]=1, lock_q SHALL be set with owner n, and only n SHALL be granted until an accepted access with lock_i[n]=0 or a cycle with req_i[n]=0 clears lock_q.
REQ-019 While lock_q is set, prio_q SHALL hold; when the lock releases, prio_q SHALL become ~owner.
REQ-020 The granted requester's addr, we, be and wdata SHALL drive the RAM in the same cycle; with no grant, the RAM we SHALL be 0.
REQ-021 Reads SHALL have a fixed latency of 1: the accepted read in cycle t SHALL give rvalid_o[n]=1 in cycle t+1, with rdata_o = RAM dout.
REQ-022 Writes SHALL produce no rvalid_o pulse.
REQ-023 The block SHALL sustain one access per cycle; back-to-back reads by different requesters SHALL give rvalid_o pulses for the correct owners in consecutive cycles.
REQ-024 A read after a write to the same address in the next cycle SHALL return the written bytes; no forwarding logic is needed beyond RAM write-first or next-cycle ordering.
REQ-025 rdata_o SHALL hold the last read value when rvalid_o=0.

Reset
REQ-026 While rst_i=1: gnt_o=0, rvalid_o=0, prio_q=0, lock_q=0, and the RAM we is forced to 0.
REQ-027 Reset asserted mid-operation SHALL suppress the pending rvalid_o pulse in the next cycle; RAM contents are not cleared.
REQ-028 In the first cycle after reset deasserts, requester 0 SHALL win a simultaneous request.

Structure
REQ-029 Shared package rl_ram_arb_pkg SHALL hold NREQ=2, the requester-index typedef and the arbiter state struct {prio, lock, owner, rd_pending, rd_owner}.
REQ-030 The block SHALL instantiate exactly one sub-module, rl_ram_1rw (ABITS, DBITS passed through), with its rst_ni tied to ~rst_i.
REQ-031 Grant logic SHALL be combinational, and the state struct SHALL be a single registered block.

Verification
REQ-032 Case 1: reset, then req_i=2'b11 for 4 cycles, all reads → gnt_o sequence 01,10,01,10; rvalid_o follows one cycle later with matching owner.
REQ-033 Case 2: requester 1 writes 0xDEADBEEF to addr 5 with be=4'b1111, then requester 0 reads addr 5 → rvalid_o=01, rdata_o=0xDEADBEEF.
REQ-034 Case 3: byte write be=4'b0010 with data 0x0000AB00 over 0xDEADBEEF at addr 5, then read → 0xDEADABEF.
REQ-035 Case 4: requester 0 locks for 3 accesses while req_i=11 → gnt_o=01 for all 3 cycles, then requester 1 is granted on release.
REQ-036 Case 5: read accepted, then rst_i=1 in the next cycle → rvalid_o stays 0, gnt_o=0, and requester 0 wins after reset.
REQ-037 Case 6: random req/lock/we for 10k cycles against a reference model → no double grant, no starvation beyond 1 cycle unlocked, all read data matches.
